packet_fifo: RTL

Parametrised packet buffer between a producer and a consumer that each use a valid/ready handshake. It carries the same data-plus-valid packet as the existing pass-through stage and adds DEPTH entries of registered storage, backpressure, an occupancy count and a peak-occupancy record. It sits on any datapath boundary where the consumer can stall, replacing a plain pass-through stage.

---
 rtl/packet_fifo.sv | 45 ++++
 1 files changed

// File: rtl/packet_fifo.sv
// packet_fifo: valid/ready packet buffer of DEPTH registered entries (in_data/in_valid/in_ready in, out_data/out_valid/out_ready out, level and max_level occupancy)
module packet_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic [LVL_W-1:0]  max_level
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  logic [LVL_W-1:0] level_nxt;
  assign in_ready = level != LVL_W'(DEPTH);
  assign out_valid = level != '0;
  assign out_data = mem[rd_ptr];
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign level_nxt = level + LVL_W'(push) - LVL_W'(pop);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      max_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      max_level <= level_nxt > max_level ? level_nxt : max_level;
    end
  end
endmodule
